// File: rtl/config_loader_if.sv
// Bitstream handshake and active-configuration bus
// between a config source and config_loader.
interface config_loader_if #(
  parameter int CONFIG_WIDTH = 112,
  parameter int WORD_WIDTH   = 8
);
  logic                    start;
  logic [WORD_WIDTH-1:0]   data_in;
  logic                    data_valid;
  logic                    data_ready;
  logic [CONFIG_WIDTH-1:0] config_out;
  logic                    config_valid;
  logic                    busy;
  logic                    done;
  logic                    error;

  modport master (
    output start, data_in, data_valid,
    input  data_ready, config_out, config_valid,
    input  busy, done, error
  );

  modport slave (
    input  start, data_in, data_valid,
    output data_ready, config_out, config_valid,
    output busy, done, error
  );
endinterface

// File: rtl/config_loader.sv
// Word-serial config loader: shadow assembly, XOR
// checksum, single-cycle commit to the switch box.
module config_loader #(
  parameter int CONFIG_WIDTH = 112,
  parameter int WORD_WIDTH   = 8
) (
  input logic            clock,
  input logic            reset,
  config_loader_if.slave bus
);
  localparam int NUM_WORDS =
    (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CNT_W  = $clog2(NUM_WORDS + 1);
  localparam int LAST_W =
    CONFIG_WIDTH - (NUM_WORDS - 1) * WORD_WIDTH;
  localparam logic [CNT_W-1:0] LAST_IDX =
    CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK
  } state_t;

  state_t                  state;
  logic [CONFIG_WIDTH-1:0] shadow;
  logic [CNT_W-1:0]        count;
  logic [WORD_WIDTH-1:0]   acc;
  logic                    xfer;

  assign xfer = bus.data_valid && bus.data_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      shadow           <= '0;
      count            <= '0;
      acc              <= '0;
      bus.data_ready   <= 1'b0;
      bus.busy         <= 1'b0;
      bus.config_out   <= '0;
      bus.config_valid <= 1'b0;
      bus.done         <= 1'b0;
      bus.error        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      // start overrides any word in flight, checksum included
      if (bus.start) begin
        state          <= LOAD;
        shadow         <= '0;
        count          <= '0;
        acc            <= '0;
        bus.error      <= 1'b0;
        bus.data_ready <= 1'b1;
        bus.busy       <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            bus.data_ready <= 1'b0;
            bus.busy       <= 1'b0;
          end
          LOAD: begin
            if (xfer) begin
              for (int k = 0; k < NUM_WORDS - 1; k++)
                if (count == CNT_W'(k))
                  shadow[k*WORD_WIDTH +: WORD_WIDTH]
                    <= bus.data_in;
              // last word may be partial; its spare bits drop
              if (count == LAST_IDX)
                shadow[CONFIG_WIDTH-1 -: LAST_W]
                  <= bus.data_in[LAST_W-1:0];
              acc   <= acc ^ bus.data_in;
              count <= count + 1'b1;
              if (count == LAST_IDX)
                state <= CHECK;
            end
          end
          CHECK: begin
            if (xfer) begin
              if (bus.data_in == acc) begin
                bus.config_out   <= shadow;
                bus.config_valid <= 1'b1;
                bus.done         <= 1'b1;
              end else begin
                bus.error <= 1'b1;
              end
              state          <= IDLE;
              bus.data_ready <= 1'b0;
              bus.busy       <= 1'b0;
            end
          end
          default: begin
            state          <= IDLE;
            bus.data_ready <= 1'b0;
            bus.busy       <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Configuration loader that sits directly upstream of a switch box and drives its `config_in` bus.
- Accepts a word-serial bitstream over a valid/ready handshake and assembles it in a shadow register.
- Checks a trailing XOR checksum word; on a match, commits the shadow register to the active configuration output in one cycle.
- The active configuration is never partially updated: the switch box sees either the old or the new image.

Parameters:
- CONFIG_WIDTH, 112, width of the configuration image (the switch box config bus).
- WORD_WIDTH, 8, width of one bitstream word.
- NUM_WORDS, ceil(CONFIG_WIDTH/WORD_WIDTH) (14 at defaults), payload words per image; derived localparam, not overridable.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins (or restarts) an image load.
- data_in  input  WORD_WIDTH  bitstream word.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  loader accepts a word this cycle.
- config_out  output  CONFIG_WIDTH  active configuration, to the switch box config_in.
- config_valid  output  1  config_out holds a committed image.
- busy  output  1  load in progress (state LOAD or CHECK).
- done  output  1  one-cycle pulse, same cycle config_out first shows a new image.
- error  output  1  sticky checksum-failure flag.

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE; all outputs 0, including config_out, config_valid, done, error, data_ready and busy.
  - Shadow register, word counter and checksum accumulator = 0.
- Handshake:
  - A word transfers on a rising edge where data_valid && data_ready.
  - data_in is ignored otherwise; data_valid may toggle freely.
  - data_ready is a registered-state decode: 1 in LOAD and CHECK, 0 in IDLE.
- States:
  - IDLE: data_ready=0, busy=0. start -> LOAD; same edge clears counter, accumulator, shadow and error.
  - LOAD: data_ready=1, busy=1.
    - Transfer k (k = 0..NUM_WORDS-1) writes shadow[k*WORD_WIDTH +: WORD_WIDTH] = data_in.
    - Bits beyond CONFIG_WIDTH-1 in the last word are discarded.
    - accumulator ^= data_in (full word, including discarded bits).
    - counter++ on each transfer.
    - Transfer with counter==NUM_WORDS-1 -> CHECK.
  - CHECK: data_ready=1, busy=1. Next transfer is the checksum word.
    - If data_in == accumulator: at that edge config_out <= shadow, config_valid <= 1, done <= 1 for exactly one cycle, state -> IDLE.
    - If mismatch: error <= 1, config_out and config_valid unchanged, state -> IDLE.
- Latency: config_out changes on the clock edge of the checksum transfer, i.e. visible in the cycle after that word is accepted.
- During a reload, config_valid and config_out keep the previous committed image; only a successful commit changes them.
- Simultaneous events:
  - start in LOAD or CHECK: abort and restart. Counter, accumulator, shadow and error are cleared; state=LOAD; any word transferred that same cycle is dropped.
  - start on the same cycle as a checksum transfer: start wins, no commit, no done.
  - start in IDLE while error=1: error clears.
- Reset mid-load: immediate return to the reset values; config_out becomes 0 and config_valid 0.
- The counter is sized clog2(NUM_WORDS+1) and never wraps; no transfers are accepted in IDLE.

Test Plan:
- Load at defaults:
  - Stimulus: start, words 0x01..0x0E back-to-back, checksum 0x0F.
  - Required: done pulses once; config_out[7:0]=0x01 and config_out[111:104]=0x0E; config_valid=1; error=0; busy=0.
- Bad checksum:
  - Stimulus: after the above, start, words 0xFF x14, checksum 0x00 (correct value 0x00).
  - Required: commit, config_out all ones.
  - Stimulus: repeat with checksum 0x01.
  - Required: error=1, no done, config_out stays all ones, config_valid stays 1.
- Backpressure/gaps:
  - Stimulus: deassert data_valid randomly between words of the 0x01..0x0E image.
  - Required: identical final config_out to the back-to-back case; busy=1 throughout the load.
- Restart mid-load:
  - Stimulus: start, 5 words of 0xAA, start again, full 0x01..0x0E + 0x0F image.
  - Required: config_out equals the ramp image; no 0xAA bytes present; done pulses once.
- Async reset:
  - Stimulus: assert reset between clock edges during LOAD after a prior commit.
  - Required: config_out=0, config_valid=0, data_ready=0 immediately, without waiting for a clock edge.
  - Stimulus: a subsequent full load.
  - Required: commits normally.
- Non-multiple width (CONFIG_WIDTH=20, WORD_WIDTH=8):
  - Stimulus: words 0x12, 0x34, 0xF5, checksum 0x12^0x34^0xF5=0xD3.
  - Required: config_out=20'h53412, done=1.
